// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  localparam int          ILEN_BYTES       = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// Request/response channel between the fetch unit (master) and the I-cache (slave).
interface fetch_if #(parameter int DATA_WIDTH = 32);

  logic                  imem_req_valid;
  logic                  imem_req_ready;
  logic [DATA_WIDTH-1:0] imem_req_addr;
  logic                  imem_resp_valid;
  logic [DATA_WIDTH-1:0] imem_resp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid,
    input  imem_resp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid,
    output imem_resp_data
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush; used for the instruction buffer and the in-flight PC queue.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 push,
  input  fetch_entry_t         push_data,
  input  logic                 pop,
  output fetch_entry_t         head,
  output logic [$clog2(DEPTH):0] count,
  output logic                 empty,
  output logic                 full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;
  logic           do_push;
  logic           do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !rst && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap without an explicit compare.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: owns the PC, issues I-cache requests under a credit limit, buffers responses
// and drops wrong-path returns after a redirect.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int                    FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  redirect,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  fetch_if.master               imem,
  output logic                  valid_f,
  output logic [DATA_WIDTH-1:0] read_data_f,
  output logic [DATA_WIDTH-1:0] PC_f,
  output logic [DATA_WIDTH-1:0] PCPlus4_f
);

  localparam int                    CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]         DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [DATA_WIDTH-1:0] STEP    = DATA_WIDTH'(ILEN_BYTES);

  logic [DATA_WIDTH-1:0] pc_q;
  logic [CW-1:0]         drop_cnt;
  logic [CW-1:0]         outstanding;
  logic [CW-1:0]         ibuf_count;
  logic [CW-1:0]         credit_used;
  logic                  fire;
  logic                  resp_ok;
  logic                  resp_keep;
  logic                  pop;
  logic                  ibuf_empty;
  logic                  ibuf_full;
  logic                  pcq_empty;
  logic                  pcq_full;
  fetch_entry_t          pcq_in;
  fetch_entry_t          pcq_head;
  fetch_entry_t          ibuf_in;
  fetch_entry_t          ibuf_head;

  // Every in-flight request holds a buffer slot until its response is consumed or dropped.
  assign credit_used         = outstanding + ibuf_count;
  assign imem.imem_req_valid = !rst && !redirect && (credit_used < DEPTH_C);
  assign imem.imem_req_addr  = pc_q;
  assign fire                = imem.imem_req_valid && imem.imem_req_ready;
  assign resp_ok             = imem.imem_resp_valid && !pcq_empty;
  assign resp_keep           = resp_ok && !redirect && (drop_cnt == '0);
  assign valid_f             = !rst && !redirect && !ibuf_empty;
  assign pop                 = valid_f && en;

  always_comb begin
    pcq_in        = '0;
    pcq_in.pc     = pc_q;
    ibuf_in       = pcq_head;
    ibuf_in.instr = imem.imem_resp_data;
  end

  // The PC queue is never flushed: dropped requests still return and must retire their entry.
  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_pc_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (1'b0),
    .push      (fire),
    .push_data (pcq_in),
    .pop       (resp_ok),
    .head      (pcq_head),
    .count     (outstanding),
    .empty     (pcq_empty),
    .full      (pcq_full)
  );

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_ibuf (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (resp_keep),
    .push_data (ibuf_in),
    .pop       (pop),
    .head      (ibuf_head),
    .count     (ibuf_count),
    .empty     (ibuf_empty),
    .full      (ibuf_full)
  );

  // On redirect everything still in flight is wrong-path, including anything already marked for drop.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      drop_cnt <= '0;
    end else if (redirect) begin
      pc_q     <= {redirect_pc[DATA_WIDTH-1:2], 2'b00};
      drop_cnt <= outstanding - CW'(resp_ok);
    end else begin
      if (fire) pc_q <= pc_q + STEP;
      if (resp_ok && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
    end
  end

  assign read_data_f = valid_f ? ibuf_head.instr        : '0;
  assign PC_f        = valid_f ? ibuf_head.pc           : '0;
  assign PCPlus4_f   = valid_f ? (ibuf_head.pc + STEP)  : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(imem.imem_resp_valid && pcq_empty));
      assert (!(resp_keep && ibuf_full && !pop));
      assert (!(fire && pcq_full && !resp_ok));
    end
  end

endmodule
